// File: rtl/hpdcache_sram_wbe_req_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_req_ctrl_pkg
// Shared definitions for the write-byte-enable SRAM request controller:
//   - default geometry of the SRAM port
//   - default request struct (we, addr, wdata, be) used as the controller's
//     request type parameter
//   - performance counter width and a saturating increment helper
// Optional feature macro used by the controller: HPDCACHE_SRAM_REQ_CTRL_PERF_EN
// ---------------------------------------------------------------------------
package hpdcache_sram_req_ctrl_pkg;

    localparam int unsigned DEF_ADDR_SIZE  = 8;
    localparam int unsigned DEF_DATA_SIZE  = 64;
    localparam int unsigned PERF_CNT_WIDTH = 32;

    typedef struct packed {
        logic                         we;
        logic [DEF_ADDR_SIZE-1:0]     addr;
        logic [DEF_DATA_SIZE-1:0]     wdata;
        logic [DEF_DATA_SIZE/8-1:0]   be;
    } hpdcache_sram_req_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(input logic [PERF_CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + PERF_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/hpdcache_sram_wbe_req_ctrl_if.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_wbe_req_ctrl_if
// Bundles the request port, the read response port and the SRAM pins of the
// request controller.
//   slave  : controller view (consumes requests, produces responses, drives SRAM)
//   master : environment view (requester, response consumer and SRAM macro)
// Handshake: a request transfers on a cycle where req_valid && req_ready; a
// response transfers on a cycle where rsp_valid && rsp_ready. The controller
// holds rsp_valid/rsp_rdata stable until the response is taken.
// ---------------------------------------------------------------------------
interface hpdcache_sram_wbe_req_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned DATA_SIZE = 64
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_SIZE-1:0]     req_addr;
    logic [DATA_SIZE-1:0]     req_wdata;
    logic [DATA_SIZE/8-1:0]   req_be;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_SIZE-1:0]     rsp_rdata;

    logic                     sram_cs;
    logic                     sram_we;
    logic [ADDR_SIZE-1:0]     sram_addr;
    logic [DATA_SIZE-1:0]     sram_wdata;
    logic [DATA_SIZE/8-1:0]   sram_wbyteenable;
    logic [DATA_SIZE-1:0]     sram_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata,
               sram_cs, sram_we, sram_addr, sram_wdata, sram_wbyteenable
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
               sram_cs, sram_we, sram_addr, sram_wdata, sram_wbyteenable
    );
endinterface

// File: rtl/hpdcache_sram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_rsp_fifo
// Registered in-order circular FIFO with wrap-around pointers modulo DEPTH.
// No bypass: data pushed into an empty FIFO appears on data_o the next cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (drops all entries)
//   push_i, data_i    write an entry
//   pop_i             remove the head entry
//   data_o            head entry (zero after reset)
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
// ---------------------------------------------------------------------------
module hpdcache_sram_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves that cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (cnt_q <= CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/hpdcache_sram_wbe_req_ctrl.sv
// ---------------------------------------------------------------------------
// hpdcache_sram_wbe_req_ctrl
// Request controller in front of a 1RW write-byte-enable SRAM. Requests are
// passed to the SRAM pins combinationally; read data (one cycle of SRAM
// latency) is captured into a response FIFO. Reads are only accepted when a
// FIFO slot is guaranteed for them, counting data still in flight.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          hpdcache_sram_wbe_req_ctrl_if.slave: request, response, SRAM
//   perf_*_cnt   saturating counters (only with HPDCACHE_SRAM_REQ_CTRL_PERF_EN)
// Optional feature macro: HPDCACHE_SRAM_REQ_CTRL_PERF_EN
// req_t must carry fields sized by ADDR_SIZE and DATA_SIZE.
// ---------------------------------------------------------------------------
module hpdcache_sram_wbe_req_ctrl
    import hpdcache_sram_req_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned RSP_DEPTH = 2,
    parameter type         req_t     = hpdcache_sram_req_t
) (
    input  logic                        clk,
    input  logic                        rst_n,
    hpdcache_sram_wbe_req_ctrl_if.slave bus
`ifdef HPDCACHE_SRAM_REQ_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0]   perf_rd_cnt,
    output logic [PERF_CNT_WIDTH-1:0]   perf_wr_cnt,
    output logic [PERF_CNT_WIDTH-1:0]   perf_stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    req_t             req;
    logic             pop, rd_room, accept, rd_issue, wr_issue;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0]   occupancy;
    logic             fifo_full, fifo_empty;

    assign req.we    = bus.req_we;
    assign req.addr  = bus.req_addr;
    assign req.wdata = bus.req_wdata;
    assign req.be    = bus.req_be;

    assign pop = bus.rsp_valid && bus.rsp_ready;

    // Slots taken once this cycle settles: stored entries plus the read whose
    // data lands next cycle, minus the entry leaving now. The rsp_ready ->
    // req_ready path through pop is combinational on purpose.
    assign occupancy = {1'b0, fifo_cnt} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign rd_room   = occupancy < (CNT_W + 1)'(RSP_DEPTH);

    assign bus.req_ready = req.we || rd_room;

    // Nothing reaches the SRAM while reset is held, even with req_valid high.
    assign accept   = rst_n && bus.req_valid && bus.req_ready;
    assign rd_issue = accept && !req.we;
    assign wr_issue = accept && req.we && (req.be != '0);

    // A write with no enabled byte is consumed without touching the SRAM.
    assign bus.sram_cs          = rd_issue || wr_issue;
    assign bus.sram_we          = req.we;
    assign bus.sram_addr        = ADDR_SIZE'(req.addr);
    assign bus.sram_wdata       = DATA_SIZE'(req.wdata);
    assign bus.sram_wbyteenable = req.be;

    assign inflight_d = rd_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    hpdcache_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_SIZE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .data_i  (bus.sram_rdata),
        .pop_i   (pop),
        .data_o  (bus.rsp_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus.rsp_valid = !fifo_empty;

    // The read reservation must make a push into a full FIFO impossible.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(inflight_q && fifo_full && !pop));
        end
    end

`ifdef HPDCACHE_SRAM_REQ_CTRL_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] perf_rd_q, perf_wr_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (rd_issue) perf_rd_q <= sat_inc(perf_rd_q);
            if (wr_issue) perf_wr_q <= sat_inc(perf_wr_q);
            if (bus.req_valid && !bus.req_ready) perf_stall_q <= sat_inc(perf_stall_q);
        end
    end

    assign perf_rd_cnt    = perf_rd_q;
    assign perf_wr_cnt    = perf_wr_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_hpdcache_sram_wbe_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hpdcache_sram_wbe_req_ctrl
// Bench for the SRAM request controller: byte-enable SRAM model, reference
// model of accepted requests and expected responses, directed scenarios
// followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_hpdcache_sram_wbe_req_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hpdcache_sram_wbe_req_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

`ifdef HPDCACHE_SRAM_REQ_CTRL_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  hpdcache_sram_wbe_req_ctrl #(
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HPDCACHE_SRAM_REQ_CTRL_PERF_EN
    ,
    .perf_rd_cnt    (perf_rd_cnt),
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- SRAM model (write-first across cycles, 1-cycle read) ----
  logic [63:0] sram_mem [256];
  logic [63:0] init_mem [256];
  logic [63:0] ref_mem  [256];

  always @(posedge clk) begin
    if (bus.sram_cs) begin
      if (bus.sram_we) begin
        for (int b = 0; b < 8; b++)
          if (bus.sram_wbyteenable[b])
            sram_mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      end else begin
        bus.sram_rdata <= sram_mem[bus.sram_addr];
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------------------
  // A read accepted in cycle c has its data visible from cycle c+2 on; reads
  // come back in acceptance order; a read may be accepted while fewer than
  // DEPTH reads are outstanding after this cycle's pop.
  logic [63:0] exp_q [$];
  int          acc_q [$];
  int          cyc = 0;
  int          n_rsp = 0;

  always @(negedge clk) begin
    logic ev, er, pop_m, acc, ecs;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_sram_cs",   64'(bus.sram_cs),   64'd0);
      check("rst_req_ready", 64'(bus.req_ready), 64'd1);
      check("rst_rsp_rdata", bus.rsp_rdata,      64'd0);
    end else begin
      ev = 1'b0;
      if (exp_q.size() > 0) ev = (cyc >= acc_q[0] + 2);
      check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      if (ev) check("rsp_rdata", bus.rsp_rdata, exp_q[0]);
      pop_m = ev && bus.rsp_ready;
      er = bus.req_we || ((exp_q.size() - (pop_m ? 1 : 0)) < DEPTH);
      check("req_ready", 64'(bus.req_ready), 64'(er));
      acc = bus.req_valid && er;
      ecs = acc && !(bus.req_we && bus.req_be == 8'h00);
      check("sram_cs", 64'(bus.sram_cs), 64'(ecs));
      check("fifo_bound", 64'(dut.u_fifo.count_o <= DEPTH), 64'd1);
      if (pop_m) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        n_rsp++;
      end
      if (acc) begin
        if (bus.req_we) begin
          for (int b = 0; b < 8; b++)
            if (bus.req_be[b]) ref_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
        end else begin
          exp_q.push_back(ref_mem[bus.req_addr]);
          acc_q.push_back(cyc);
        end
      end
      cyc++;
    end
  end

  // ---------------- driver tasks ---------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
  endtask

  // Presents one request and returns after the edge that accepts it.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [63:0] wd,
                        input logic [7:0] be, output int waits, output logic cs_seen);
    logic got;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    waits = 0;
    cs_seen = 1'b0;
    got = 1'b0;
    while (1) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        cs_seen = bus.sram_cs;
      end
      @(posedge clk);
      #1;
      if (got) break;
      waits++;
      if (waits > 50) begin
        check("req_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  // Counts negedges until rsp_valid is seen.
  task automatic wait_rsp(output int lat, output logic [63:0] data);
    lat = 0;
    data = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) begin
        data = bus.rsp_rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus -------------------------------------------------
  initial begin
    int          w, lat, n0;
    logic        cs;
    logic [63:0] d;
    logic        last_ready;

    for (int i = 0; i < 256; i++) begin
      init_mem[i] = {$urandom, $urandom};
      sram_mem[i] = init_mem[i];
      ref_mem[i]  = init_mem[i];
    end

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;

    // Reset held with a pending read request.
    step(3);
    idle();
    rst_n = 1'b1;
    step(2);
    check("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);

    bus.rsp_ready = 1'b1;

    // Byte-enable merge: full write, low-half write, readback.
    do_req(1'b1, 8'h10, 64'h1122334455667788, 8'hFF, w, cs);
    check("be_w1_cs", 64'(cs), 64'd1);
    do_req(1'b1, 8'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, w, cs);
    check("be_w2_wait", 64'(w), 64'd0);
    do_req(1'b0, 8'h10, 64'd0, 8'h00, w, cs);
    idle();
    wait_rsp(lat, d);
    check("be_latency", 64'(lat), 64'd2);
    check("be_data", d, 64'h11223344AAAAAAAA);

    // Zero byte-enable write leaves memory untouched.
    do_req(1'b1, 8'h20, {$urandom, $urandom}, 8'h00, w, cs);
    check("zbe_cs", 64'(cs), 64'd0);
    check("zbe_wait", 64'(w), 64'd0);
    do_req(1'b0, 8'h20, 64'd0, 8'h00, w, cs);
    idle();
    wait_rsp(lat, d);
    check("zbe_data", d, init_mem[8'h20]);

    // Back-to-back reads at full rate.
    n0 = n_rsp;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 8'(i), 64'd0, 8'h00, w, cs);
      check("b2b_wait", 64'(w), 64'd0);
    end
    idle();
    step(3);
    check("b2b_count", 64'(n_rsp - n0), 64'd8);

    // Backpressure: two reads fit, the third stalls until the consumer drains.
    bus.rsp_ready = 1'b0;
    n0 = n_rsp;
    do_req(1'b0, 8'h40, 64'd0, 8'h00, w, cs);
    check("bp_r0_wait", 64'(w), 64'd0);
    do_req(1'b0, 8'h41, 64'd0, 8'h00, w, cs);
    check("bp_r1_wait", 64'(w), 64'd0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h42;
    repeat (4) begin
      @(negedge clk);
      check("bp_stall", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    do_req(1'b0, 8'h42, 64'd0, 8'h00, w, cs);
    check("bp_r2_wait", 64'(w), 64'd0);
    do_req(1'b0, 8'h43, 64'd0, 8'h00, w, cs);
    check("bp_r3_wait", 64'(w), 64'd0);
    idle();
    step(6);
    check("bp_count", 64'(n_rsp - n0), 64'd4);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset while a read is in flight.
    do_req(1'b0, 8'h50, 64'd0, 8'h00, w, cs);
    idle();
    #1;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    check("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mrst_fifo_cnt", 64'(dut.u_fifo.count_o), 64'd0);
`ifdef HPDCACHE_SRAM_REQ_CTRL_PERF_EN
    check("mrst_perf_rd", 64'(perf_rd_cnt), 64'd0);
    check("mrst_perf_wr", 64'(perf_wr_cnt), 64'd0);
    check("mrst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif

    // Randomized traffic; a stalled request is held until accepted.
    last_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req_valid || last_ready) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = 8'($urandom_range(0, 15));
        bus.req_wdata = {$urandom, $urandom};
        bus.req_be    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      last_ready = bus.req_ready;
      @(posedge clk);
      #1;
    end

    idle();
    bus.rsp_ready = 1'b1;
    step(8);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_rsp_valid", 64'(bus.rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hpdcache_sram_wbe_req_ctrl.md
Name: hpdcache_sram_wbe_req_ctrl

Overview:
- Request controller placed directly upstream of the write-byte-enable 1RW SRAM wrapper.
- Accepts read/write requests over a valid/ready handshake and drives the SRAM cs/we/addr/wdata/wbyteenable pins.
- Captures the 1-cycle-latency SRAM read data into a response FIFO.
- Provides backpressure so that no read data is ever lost, and sustains one request per cycle when the consumer is always ready.

Parameters:
- ADDR_SIZE, 8, SRAM address width
- DATA_SIZE, 64, SRAM data width; must be a multiple of 8
- RSP_DEPTH, 2, read response FIFO entries; minimum 1; 2 or more gives full read throughput

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_we  input  1  1=write, 0=read
- req_addr  input  ADDR_SIZE  request address
- req_wdata  input  DATA_SIZE  write data
- req_be  input  DATA_SIZE/8  write byte enables
- rsp_valid  output  1  read data valid
- rsp_ready  input  1  consumer ready
- rsp_rdata  output  DATA_SIZE  read data
- sram_cs  output  1  SRAM chip select
- sram_we  output  1  SRAM write enable
- sram_addr  output  ADDR_SIZE  SRAM address
- sram_wdata  output  DATA_SIZE  SRAM write data
- sram_wbyteenable  output  DATA_SIZE/8  SRAM byte enables
- sram_rdata  input  DATA_SIZE  SRAM read data, valid one cycle after a read with cs=1

Behaviour:
- One clock; reset is asynchronous, active-low (rst_n).
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, sram_cs=0, inflight=0, FIFO count=0, pointers=0.
- SRAM outputs are combinational from the request port:
  - sram_cs = req_valid && req_ready && !(req_we && req_be==0)
  - sram_we = req_we; sram_addr = req_addr; sram_wdata = req_wdata; sram_wbyteenable = req_be
- Writes:
  - Always accepted: req_ready=1 whenever req_we=1.
  - No response is generated.
  - A write with req_be==0 is accepted and consumed without asserting sram_cs.
- Reads:
  - pop = rsp_valid && rsp_ready.
  - A read is accepted iff (fifo_cnt + inflight - pop) < RSP_DEPTH, i.e. space is reserved for read data still in flight.
  - The path from rsp_ready to req_ready is combinational, by design.
- inflight register: set on the cycle a read is issued; in the next cycle sram_rdata is pushed into the FIFO and inflight clears unless a new read is issued.
- Response FIFO:
  - Registered, in-order circular buffer with wrap-around pointers modulo RSP_DEPTH.
  - rsp_valid = (fifo_cnt != 0); rsp_rdata = head entry.
  - Push and pop in the same cycle leaves the count unchanged.
- Ordering: requests are issued in acceptance order. A read following a write to the same address returns the merged data; this relies on SRAM write-first ordering across cycles, with no forwarding in this block.
- Empty FIFO with a same-cycle push: rsp_valid rises the cycle after the push; there is no FIFO bypass.
- Overflow cannot occur by construction. Verification must assert fifo_cnt <= RSP_DEPTH and that no push happens while full without a pop.
- Reset asserted mid-operation: in-flight read data is discarded and all FIFO entries are dropped.

Optional Feature:
- Macro: HPDCACHE_SRAM_REQ_CTRL_PERF_EN.
- Defined:
  - Adds three 32-bit saturating counters, reset to 0: perf_rd_cnt (accepted reads), perf_wr_cnt (accepted writes with req_be!=0), perf_stall_cnt (cycles with req_valid && !req_ready).
  - Exposes them as output ports of the same names.
- Undefined: no counters and no such ports exist.

Decomposition:
- Shared package hpdcache_sram_req_ctrl_pkg: request struct (we, addr, wdata, be), parameterised via type parameters in the module; perf counter width constant PERF_CNT_WIDTH=32.
- One sub-module: hpdcache_sram_rsp_fifo, a synchronous FIFO parameterised by depth and width with push/pop/full/empty/count, reusable elsewhere.

Test Plan:
- Reset: hold rst_n=0 with req_valid=1 -> sram_cs=0, rsp_valid=0, req_ready=1; release and verify idle outputs.
- Byte-enable write then read: write addr 0x10 data 0x1122334455667788 be 0xFF; write 0x10 data 0xAAAAAAAAAAAAAAAA be 0x0F; read 0x10 -> rsp_rdata=0x11223344AAAAAAAA, exactly 2 cycles after read acceptance.
- Zero byte-enable write: write addr 0x20 be 0x00 -> accepted, sram_cs stays 0, memory at 0x20 unchanged on readback.
- Back-to-back reads with rsp_ready=1, RSP_DEPTH=2: 8 reads to addr 0..7 -> one accepted per cycle, 8 responses in address order, no bubbles.
- Backpressure: rsp_ready=0, issue 4 reads -> only 2 accepted (FIFO plus inflight reservation), req_ready=0 thereafter; raise rsp_ready -> the remaining 2 are accepted, all 4 returned in order with none lost.
- Reset mid-flight: issue read, assert rst_n=0 on the next cycle -> after release rsp_valid=0, fifo_cnt=0; with PERF_EN defined, all counters read 0.
